// File: rtl/alu_writeback.sv
// Result-retirement stage for the 19-bit ALU: writes single-word results in one cycle and
// MUL results as low-then-high halves, and maintains Z/N/H flags plus a retired-op counter.
module alu_writeback #(
  parameter int unsigned DATA_W = 19,
  parameter int unsigned REG_AW = 3,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4:0]          in_opcode,
  input  logic [2*DATA_W-1:0] in_result,
  input  logic [REG_AW-1:0]   in_rd,
  input  logic [REG_AW-1:0]   in_rd_hi,
  output logic                rf_we,
  output logic [REG_AW-1:0]   rf_waddr,
  output logic [DATA_W-1:0]   rf_wdata,
  output logic                done,
  output logic                flag_z,
  output logic                flag_n,
  output logic                flag_h,
  output logic [CNT_W-1:0]    retired
);

  localparam logic [4:0] OpMul          = 5'b00010;
  localparam logic [4:0] OpFirstInvalid = 5'b01010;

  typedef enum logic [1:0] {StIdle, StWrLo, StWrHi} state_e;

  state_e                state_q, state_d;
  logic [4:0]            op_q;
  logic [2*DATA_W-1:0]   res_q;
  logic [REG_AW-1:0]     rd_q, rd_hi_q;
  logic                  flag_z_q, flag_n_q, flag_h_q;
  logic [CNT_W-1:0]      retired_q;

  logic                  accept;
  logic                  held_mul, held_valid;
  logic                  flags_upd;
  logic                  flag_z_d, flag_n_d, flag_h_d;
  logic [DATA_W-1:0]     res_lo, res_hi;

  assign held_mul   = (op_q == OpMul);
  assign held_valid = (op_q < OpFirstInvalid);
  assign res_lo     = res_q[DATA_W-1:0];
  assign res_hi     = res_q[2*DATA_W-1:DATA_W];
  assign accept     = in_valid && in_ready;

  // While rst is high the stage presents as idle: no ready, no write, no done.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    done     = 1'b0;
    if (!rst) begin
      unique case (state_q)
        StIdle: begin
          in_ready = 1'b1;
          if (in_valid) state_d = StWrLo;
        end
        StWrLo: begin
          rf_we    = held_valid;
          rf_waddr = rd_q;
          rf_wdata = res_lo;
          if (held_mul) begin
            state_d = StWrHi;
          end else begin
            done     = 1'b1;
            in_ready = 1'b1;
            state_d  = in_valid ? StWrLo : StIdle;
          end
        end
        StWrHi: begin
          rf_we    = 1'b1;
          rf_waddr = rd_hi_q;
          rf_wdata = res_hi;
          done     = 1'b1;
          state_d  = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Invalid opcodes retire without touching the flags.
  always_comb begin
    flags_upd = done && held_valid;
    if (held_mul) begin
      flag_z_d = (res_q == '0);
      flag_n_d = res_q[2*DATA_W-1];
      flag_h_d = (res_hi != '0);
    end else begin
      flag_z_d = (res_lo == '0);
      flag_n_d = res_lo[DATA_W-1];
      flag_h_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      op_q      <= '0;
      res_q     <= '0;
      rd_q      <= '0;
      rd_hi_q   <= '0;
      flag_z_q  <= 1'b0;
      flag_n_q  <= 1'b0;
      flag_h_q  <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q    <= in_opcode;
        res_q   <= in_result;
        rd_q    <= in_rd;
        rd_hi_q <= in_rd_hi;
      end
      if (flags_upd) begin
        flag_z_q <= flag_z_d;
        flag_n_q <= flag_n_d;
        flag_h_q <= flag_h_d;
      end
      if (done) retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign flag_z  = flag_z_q;
  assign flag_n  = flag_n_q;
  assign flag_h  = flag_h_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_alu_writeback.sv
// Self-checking bench for alu_writeback: directed scenarios plus a randomized run against a
// slot-schedule reference model, and a retired-counter wrap test.
module tb_alu_writeback;

  localparam int DW = 19;
  localparam int AW = 3;
  localparam int CW = 16;
  localparam logic [4:0] MUL = 5'b00010;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [4:0]    in_opcode = '0;
  logic [2*DW-1:0] in_result = '0;
  logic [AW-1:0] in_rd = '0;
  logic [AW-1:0] in_rd_hi = '0;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          done;
  logic          flag_z, flag_n, flag_h;
  logic [CW-1:0] retired;

  int checks = 0;
  int errors = 0;

  // Architectural model state
  logic          ez = 1'b0, en = 1'b0, eh = 1'b0;
  logic [CW-1:0] eret = '0;

  logic [63:0] got, exp;

  typedef struct {
    int            cyc;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          done;
    logic          hi;
    logic          upd;
    logic          z, n, h;
  } slot_t;

  slot_t sched[$];

  always #5 clk = ~clk;

  alu_writeback #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_result(in_result), .in_rd(in_rd), .in_rd_hi(in_rd_hi),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .done(done),
    .flag_z(flag_z), .flag_n(flag_n), .flag_h(flag_h), .retired(retired)
  );

  task automatic drive(input logic v, input logic [4:0] op, input logic [2*DW-1:0] res,
                       input logic [AW-1:0] rd, input logic [AW-1:0] rdhi);
    in_valid  = v;
    in_opcode = op;
    in_result = res;
    in_rd     = rd;
    in_rd_hi  = rdhi;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 5'd0, '0, '0, '0);
    @(negedge clk);
    got = {in_ready, rf_we}; exp = {1'b0, 1'b0};
    checks++; if (got !== exp) begin errors++; $display("FAIL reset_hold got %h want %h", got, exp); end
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    got = {in_ready, rf_we, rf_waddr, rf_wdata, done, flag_z, flag_n, flag_h, retired};
    exp = {1'b1, 1'b0, 3'd0, 19'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    checks++; if (got !== exp) begin errors++; $display("FAIL reset_values got %h want %h", got, exp); end
    // Abort a MUL while it sits in its low-half write
    next_cycle();
    drive(1'b1, MUL, 38'h3F_FFC0_0001, 3'd4, 3'd5);
    next_cycle();
    drive(1'b0, 5'd0, '0, '0, '0);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_low got %b want 0", in_ready); end
    next_cycle();
    @(negedge clk);
    got = {rf_we, done, in_ready}; exp = {1'b0, 1'b0, 1'b0};
    checks++; if (got !== exp) begin errors++; $display("FAIL reset_abort got %h want %h", got, exp); end
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    got = {in_ready, rf_we, done, flag_z, flag_n, flag_h, retired};
    exp = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    checks++; if (got !== exp) begin errors++; $display("FAIL reset_release got %h want %h", got, exp); end
    next_cycle();
    @(negedge clk);
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_no_hi_write got %b want 0", rf_we); end
    ez = 1'b0; en = 1'b0; eh = 1'b0; eret = '0;
  endtask

  task automatic test_add();
    next_cycle();
    drive(1'b1, 5'b00000, 38'h0_0000_0005, 3'd3, 3'd0);
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL add_ready got %b want 1", in_ready); end
    next_cycle();
    drive(1'b0, 5'd0, '0, '0, '0);
    @(negedge clk);
    got = {rf_we, rf_waddr, rf_wdata, done}; exp = {1'b1, 3'd3, 19'd5, 1'b1};
    checks++; if (got !== exp) begin errors++; $display("FAIL add_write got %h want %h", got, exp); end
    ez = 1'b0; en = 1'b0; eh = 1'b0; eret = eret + 1'b1;
    next_cycle();
    @(negedge clk);
    got = {rf_we, flag_z, flag_n, flag_h, retired}; exp = {1'b0, ez, en, eh, eret};
    checks++; if (got !== exp) begin errors++; $display("FAIL add_status got %h want %h", got, exp); end
  endtask

  task automatic test_mul();
    logic [2*DW-1:0] res;
    logic [DW-1:0] lo, hi;
    res = 38'h3F_FFC0_0001;
    lo = res[DW-1:0];
    hi = res[2*DW-1:DW];
    next_cycle();
    drive(1'b1, MUL, res, 3'd1, 3'd2);
    next_cycle();
    drive(1'b0, 5'd0, '0, '0, '0);
    @(negedge clk);
    got = {rf_we, rf_waddr, rf_wdata, done, in_ready}; exp = {1'b1, 3'd1, lo, 1'b0, 1'b0};
    checks++; if (got !== exp) begin errors++; $display("FAIL mul_lo got %h want %h", got, exp); end
    next_cycle();
    @(negedge clk);
    got = {rf_we, rf_waddr, rf_wdata, done, in_ready}; exp = {1'b1, 3'd2, hi, 1'b1, 1'b0};
    checks++; if (got !== exp) begin errors++; $display("FAIL mul_hi got %h want %h", got, exp); end
    ez = (res == '0); en = res[2*DW-1]; eh = (hi != '0); eret = eret + 1'b1;
    next_cycle();
    @(negedge clk);
    got = {in_ready, rf_we, flag_z, flag_n, flag_h, retired}; exp = {1'b1, 1'b0, ez, en, eh, eret};
    checks++; if (got !== exp) begin errors++; $display("FAIL mul_status got %h want %h", got, exp); end
  endtask

  task automatic test_back_to_back();
    next_cycle();
    drive(1'b1, 5'b00001, 38'd0, 3'd6, 3'd0);
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready0 got %b want 1", in_ready); end
    next_cycle();
    drive(1'b1, 5'b00011, 38'h0_0004_0000, 3'd7, 3'd0);
    @(negedge clk);
    got = {in_ready, rf_we, rf_waddr, rf_wdata, done}; exp = {1'b1, 1'b1, 3'd6, 19'd0, 1'b1};
    checks++; if (got !== exp) begin errors++; $display("FAIL b2b_first got %h want %h", got, exp); end
    ez = 1'b1; en = 1'b0; eh = 1'b0; eret = eret + 1'b1;
    next_cycle();
    drive(1'b0, 5'd0, '0, '0, '0);
    @(negedge clk);
    got = {rf_we, rf_waddr, rf_wdata, done, flag_z, flag_n, retired};
    exp = {1'b1, 3'd7, 19'h40000, 1'b1, ez, en, eret};
    checks++; if (got !== exp) begin errors++; $display("FAIL b2b_second got %h want %h", got, exp); end
    ez = 1'b0; en = 1'b1; eh = 1'b0; eret = eret + 1'b1;
    next_cycle();
    @(negedge clk);
    got = {rf_we, flag_z, flag_n, flag_h, retired}; exp = {1'b0, ez, en, eh, eret};
    checks++; if (got !== exp) begin errors++; $display("FAIL b2b_status got %h want %h", got, exp); end
  endtask

  task automatic test_invalid();
    next_cycle();
    drive(1'b1, 5'b11111, 38'd0, 3'd2, 3'd3);
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL inv_ready got %b want 1", in_ready); end
    next_cycle();
    drive(1'b0, 5'd0, '0, '0, '0);
    @(negedge clk);
    got = {rf_we, done}; exp = {1'b0, 1'b1};
    checks++; if (got !== exp) begin errors++; $display("FAIL inv_cycle got %h want %h", got, exp); end
    eret = eret + 1'b1;
    next_cycle();
    @(negedge clk);
    got = {flag_z, flag_n, flag_h, retired}; exp = {ez, en, eh, eret};
    checks++; if (got !== exp) begin errors++; $display("FAIL inv_status got %h want %h", got, exp); end
  endtask

  // Each accepted op books write slots at absolute cycle numbers; in_ready is high exactly when
  // the next cycle is free and the current cycle is not the high half of a MUL.
  task automatic test_random();
    int cyc;
    int n;
    int r;
    logic [4:0] op;
    logic [63:0] raw;
    logic [2*DW-1:0] res;
    logic has_cur, next_busy, exp_rdy;
    slot_t cur, s;
    cyc = 0;
    n = 600;
    sched.delete();
    for (int i = 0; i < n; i++) begin
      next_cycle();
      r = $urandom_range(0, 9);
      if (r < 3) op = MUL;
      else if (r == 3) op = 5'($urandom_range(10, 31));
      else begin
        op = 5'($urandom_range(0, 9));
        if (op == MUL) op = 5'd1;
      end
      raw = {$urandom, $urandom};
      res = raw[2*DW-1:0];
      r = $urandom_range(0, 7);
      if (r == 0) res = '0;
      else if (r == 1) res[2*DW-1:DW] = '0;
      drive((i < n - 3) && ($urandom_range(0, 9) < 7), op, res,
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      @(negedge clk);
      has_cur = (sched.size() > 0) && (sched[0].cyc == cyc);
      if (has_cur) cur = sched[0];
      next_busy = (sched.size() > 0) && (sched[$].cyc == cyc + 1);
      exp_rdy = !next_busy && !(has_cur && cur.hi);
      checks++;
      if (in_ready !== exp_rdy) begin
        errors++; $display("FAIL rand_ready cyc %0d got %b want %b", cyc, in_ready, exp_rdy);
      end
      if (has_cur) begin
        got = {rf_we, done}; exp = {cur.we, cur.done};
        if (cur.we) begin
          got = {rf_we, done, rf_waddr, rf_wdata}; exp = {cur.we, cur.done, cur.addr, cur.data};
        end
      end else begin
        got = {rf_we, done, rf_waddr, rf_wdata}; exp = '0;
      end
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL rand_write cyc %0d got %h want %h", cyc, got, exp);
      end
      got = {flag_z, flag_n, flag_h, retired}; exp = {ez, en, eh, eret};
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL rand_status cyc %0d got %h want %h", cyc, got, exp);
      end
      if (has_cur) begin
        if (cur.done) eret = eret + 1'b1;
        if (cur.upd) begin ez = cur.z; en = cur.n; eh = cur.h; end
        void'(sched.pop_front());
      end
      if (in_valid && exp_rdy) begin
        if (in_opcode == MUL) begin
          s = '{cyc + 1, 1'b1, in_rd, in_result[DW-1:0], 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
          sched.push_back(s);
          s = '{cyc + 2, 1'b1, in_rd_hi, in_result[2*DW-1:DW], 1'b1, 1'b1, 1'b1,
                in_result == '0, in_result[2*DW-1], in_result[2*DW-1:DW] != '0};
          sched.push_back(s);
        end else begin
          s = '{cyc + 1, in_opcode < 5'd10, in_rd, in_result[DW-1:0], 1'b1, 1'b0,
                in_opcode < 5'd10, in_result[DW-1:0] == '0, in_result[DW-1], 1'b0};
          sched.push_back(s);
        end
      end
      cyc++;
    end
  endtask

  task automatic test_counter_wrap();
    next_cycle();
    rst = 1'b1;
    drive(1'b0, 5'd0, '0, '0, '0);
    next_cycle();
    rst = 1'b0;
    drive(1'b1, 5'b00000, '0, 3'd0, 3'd0);
    repeat (65535) @(posedge clk);
    #1;
    drive(1'b0, 5'd0, '0, '0, '0);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (retired !== 16'hFFFF) begin
      errors++; $display("FAIL wrap_max got %h want ffff", retired);
    end
    drive(1'b1, 5'b00000, '0, 3'd0, 3'd0);
    @(posedge clk);
    #1;
    drive(1'b0, 5'd0, '0, '0, '0);
    @(posedge clk);
    @(negedge clk);
    got = {flag_z, flag_n, flag_h, retired}; exp = {1'b1, 1'b0, 1'b0, 16'd0};
    checks++; if (got !== exp) begin errors++; $display("FAIL wrap_zero got %h want %h", got, exp); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_back_to_back();
    test_invalid();
    test_random();
    test_counter_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
